// File: rtl/vga_frame_grabber.sv
// Receive side of the 640x480 VGA link: recovers frame timing from h_sync/v_sync,
// locks onto it, and writes a 4:1 decimated 160x120 image into video memory.
module vga_frame_grabber #(
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int PIXEL_DELAY = 1,
  parameter int DATA_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rgb_in,
  input  logic              h_sync,
  input  logic              v_sync,
  output logic [14:0]       data_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              write_enable,
  output logic              locked,
  output logic              frame_done,
  output logic              sync_error
);

  localparam int H_TOTAL = H_BACK + H_ACTIVE + H_FRONT + H_SYNC;
  localparam int V_TOTAL = V_BACK + V_ACTIVE + V_FRONT + V_SYNC;
  localparam int MEM_W   = 160;

  localparam logic [9:0]         H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]         V_LAST = 10'(V_TOTAL - 1);
  localparam logic signed [11:0] X_OFF  = 12'(H_BACK + PIXEL_DELAY);
  localparam logic signed [11:0] Y_OFF  = 12'(V_BACK);
  localparam logic signed [11:0] X_LIM  = 12'(H_ACTIVE);
  localparam logic signed [11:0] Y_LIM  = 12'(V_ACTIVE);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ALIGN  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  function automatic logic [9:0] sat_inc(input logic [9:0] cnt);
    return (cnt == 10'h3ff) ? cnt : cnt + 10'd1;
  endfunction

  function automatic logic [14:0] tile_addr(input logic [7:0] tx, input logic [6:0] ty);
    return 15'(ty) * 15'(MEM_W) + 15'(tx);
  endfunction

  logic                     h_sync_q, v_sync_q;
  logic [9:0]               h_cnt_q, v_cnt_q;
  logic [1:0]               state, state_nxt;
  logic                     h_rise, v_rise;
  logic [9:0]               h_cnt, v_cnt;
  logic                     line_err, frame_err, fault;
  logic signed [11:0]       x_p0, y_p0;
  logic                     x_ok, y_ok, vld_p0;
  logic [14:0]              addr_p0;
  logic                     vld_p1, locked_p1;
  logic [14:0]              addr_p1;
  logic [DATA_W-1:0]        data_p1;

  // p0: edge detect, position counters and timing checks for the current input cycle
  assign h_rise = h_sync & ~h_sync_q;
  assign v_rise = v_sync & ~v_sync_q;

  always_comb begin
    h_cnt = h_rise ? 10'd0 : sat_inc(h_cnt_q);
    if (v_rise) begin
      v_cnt = 10'd0;
    end else if (h_rise) begin
      v_cnt = sat_inc(v_cnt_q);
    end else begin
      v_cnt = v_cnt_q;
    end
    // h_cnt_q == H_LAST without an h_rise means the sync pulse never came
    line_err  = h_rise ? (h_cnt_q != H_LAST) : (h_cnt_q == H_LAST);
    frame_err = v_rise ? (v_cnt_q != V_LAST) : (h_rise && (v_cnt_q >= V_LAST));
    fault     = line_err | frame_err;
  end

  assign x_p0    = $signed({2'b00, h_cnt}) - X_OFF;
  assign y_p0    = $signed({2'b00, v_cnt}) - Y_OFF;
  assign x_ok    = (x_p0 >= 12'sd0) && (x_p0 < X_LIM) && (x_p0[1:0] == 2'b00);
  assign y_ok    = (y_p0 >= 12'sd0) && (y_p0 < Y_LIM) && (y_p0[1:0] == 2'b00);
  assign vld_p0  = (state == LOCKED) && !fault && x_ok && y_ok;
  assign addr_p0 = tile_addr(x_p0[9:2], y_p0[8:2]);

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (v_rise) state_nxt = ALIGN;
      ALIGN: begin
        if (fault) begin
          state_nxt = SEARCH;
        end else if (v_rise) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: if (fault) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // p1: registered write port and lock flag
  always_ff @(posedge clk) begin
    if (reset) begin
      h_sync_q  <= 1'b1;
      v_sync_q  <= 1'b1;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      state     <= SEARCH;
      locked_p1 <= 1'b0;
      vld_p1    <= 1'b0;
      addr_p1   <= 15'd0;
      data_p1   <= '0;
    end else begin
      h_sync_q  <= h_sync;
      v_sync_q  <= v_sync;
      h_cnt_q   <= h_cnt;
      v_cnt_q   <= v_cnt;
      state     <= state_nxt;
      locked_p1 <= (state_nxt == LOCKED);
      vld_p1    <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= rgb_in;
      end
    end
  end

  assign write_enable = vld_p1;
  assign data_addr    = addr_p1;
  assign data_out     = data_p1;
  assign locked       = locked_p1;
  // Pulses coincide with the sync edge that triggers them
  assign frame_done   = !reset && (state == LOCKED) && v_rise && !fault;
  assign sync_error   = !reset && (state == LOCKED) && fault;

endmodule
